// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin arbiter serialising one requester word at a time, LSB first
module serial_tx_arbiter #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] data_in,
    output logic [3:0]     grant,
    output logic [1:0]     gnt_id,
    output logic           out,
    output logic           valid,
    output logic           done,
    output logic           empty
);

    localparam int N  = 4;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    logic [1:0]     ptr;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   shreg;

    logic [1:0]     win_id;
    logic           win_found;
    logic [1:0]     idx;

    // Round-robin search: start at ptr, wrap 3->0, first set request wins
    always_comb begin
        win_id    = ptr;
        win_found = 1'b0;
        idx       = ptr;
        for (int k = 0; k < N; k++) begin
            idx = ptr + 2'(k);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    // Control FSM; every output is a register updated here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= 4'b0000;
            gnt_id <= 2'd0;
            out    <= 1'b0;
            valid  <= 1'b0;
            done   <= 1'b0;
            empty  <= 1'b1;
            ptr    <= 2'd0;
            cnt    <= '0;
            shreg  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    out   <= 1'b0;
                    if (win_found) begin
                        shreg  <= data_in[win_id*W +: W];
                        grant  <= 4'b0001 << win_id;
                        gnt_id <= win_id;
                        cnt    <= '0;
                        empty  <= 1'b0;
                        state  <= SHIFT;
                    end else begin
                        grant <= 4'b0000;
                        empty <= 1'b1;
                    end
                end
                SHIFT: begin
                    out   <= shreg[0];
                    shreg <= shreg >> 1;
                    valid <= 1'b1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    out   <= 1'b0;
                    done  <= 1'b1;
                    grant <= 4'b0000;
                    ptr   <= gnt_id + 2'd1;
                    empty <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - directed vector bench for serial_tx_arbiter
module tb_serial_tx_arbiter;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] data_in;
    logic [3:0]     grant;
    logic [1:0]     gnt_id;
    logic           out;
    logic           valid;
    logic           done;
    logic           empty;

    int tests = 0;
    int fails = 0;

    serial_tx_arbiter #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data_in (data_in),
        .grant   (grant),
        .gnt_id  (gnt_id),
        .out     (out),
        .valid   (valid),
        .done    (done),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        logic [3:0]  grant;
        logic [1:0]  gnt_id;
        logic        out;
        logic        valid;
        logic        done;
        logic        empty;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input int id, input logic [3:0] dw, input bit drop);
        logic [3:0] g;
        g = 4'b0001 << id;
        step();
        chk("e0_grant", 16'(grant), 16'(g));
        chk("e0_gnt_id", 16'(gnt_id), 16'(id));
        chk("e0_empty", 16'(empty), 16'd0);
        chk("e0_valid", 16'(valid), 16'd0);
        chk("e0_done", 16'(done), 16'd0);
        if (drop) req = 4'b0000;
        for (int i = 0; i < W; i++) begin
            step();
            chk("bit_out", 16'(out), 16'(dw[i]));
            chk("bit_valid", 16'(valid), 16'd1);
            chk("bit_grant", 16'(grant), 16'(g));
        end
        step();
        chk("done_pulse", 16'(done), 16'd1);
        chk("done_grant", 16'(grant), 16'd0);
        chk("done_gnt_id", 16'(gnt_id), 16'(id));
        chk("done_empty", 16'(empty), 16'd1);
        chk("done_valid", 16'(valid), 16'd0);
    endtask

    task automatic abort_then(input logic [3:0] req_after, input int id, input logic [3:0] dw);
        req = 4'b0100;
        step();
        chk("abort_e0_grant", 16'(grant), 16'h0004);
        req = 4'b0000;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 16'(valid), 16'd0);
        chk("async_grant", 16'(grant), 16'd0);
        chk("async_done", 16'(done), 16'd0);
        chk("async_empty", 16'(empty), 16'd1);
        chk("async_out", 16'(out), 16'd0);
        chk("async_gnt_id", 16'(gnt_id), 16'd0);
        req = req_after;
        #2 rst = 1'b0;
        word(id, dw, 1'b1);
    endtask

    // Per-cycle invariants on grant, valid/empty and done spacing
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if ((grant & (grant - 4'd1)) != 4'd0) begin
                fails++;
                $display("FAIL inv_onehot: grant %b", grant);
            end
            tests++;
            if (valid && empty) begin
                fails++;
                $display("FAIL inv_valid_empty: valid %b empty %b expected not both", valid, empty);
            end
            tests++;
            if (done && prev_done) begin
                fails++;
                $display("FAIL inv_done_twice: done %b prev %b expected not both", done, prev_done);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'b0001, 16'h000B, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0000, 16'h000B, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'b0000, 16'h0000, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'b0000, 16'h0000, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'b0000, 16'h0000, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'b0000, 16'h0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{4'b0000, 16'h0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{4'b0100, 16'h0600, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b0100, 16'h0600, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'b0000, 16'h0000, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'b0000, 16'h0000, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'b0000, 16'h0000, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{4'b0000, 16'h0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{4'b0000, 16'h0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1};

        rst     = 1'b1;
        req     = 4'b0000;
        data_in = '0;
        #12;
        chk("rst_grant", 16'(grant), 16'd0);
        chk("rst_gnt_id", 16'(gnt_id), 16'd0);
        chk("rst_out", 16'(out), 16'd0);
        chk("rst_valid", 16'(valid), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_empty", 16'(empty), 16'd1);
        rst = 1'b0;

        for (int v = 0; v < 14; v++) begin
            req     = vecs[v].req;
            data_in = vecs[v].data;
            step();
            chk($sformatf("vec%0d_grant", v), 16'(grant), 16'(vecs[v].grant));
            chk($sformatf("vec%0d_gnt_id", v), 16'(gnt_id), 16'(vecs[v].gnt_id));
            chk($sformatf("vec%0d_out", v), 16'(out), 16'(vecs[v].out));
            chk($sformatf("vec%0d_valid", v), 16'(valid), 16'(vecs[v].valid));
            chk($sformatf("vec%0d_done", v), 16'(done), 16'(vecs[v].done));
            chk($sformatf("vec%0d_empty", v), 16'(empty), 16'(vecs[v].empty));
        end

        rst = 1'b1;
        #3 rst = 1'b0;
        data_in = 16'h9E5B;
        req     = 4'b1111;
        word(0, 4'hB, 1'b0);
        word(1, 4'h5, 1'b0);
        word(2, 4'hE, 1'b0);
        word(3, 4'h9, 1'b0);
        word(0, 4'hB, 1'b0);
        req = 4'b0010;
        word(1, 4'h5, 1'b0);
        req = 4'b0011;
        word(0, 4'hB, 1'b0);
        word(1, 4'h5, 1'b0);
        req = 4'b0000;
        step();
        chk("idle_empty", 16'(empty), 16'd1);
        chk("idle_grant", 16'(grant), 16'd0);
        chk("idle_done", 16'(done), 16'd0);

        abort_then(4'b0110, 1, 4'h5);
        abort_then(4'b1000, 3, 4'h9);
        step();
        chk("final_empty", 16'(empty), 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_tx_arbiter.md
SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 Parameter W, default 4: data word width in bits; legal range 2..15.
REQ-002 Parameter N, fixed at 4: number of requesters; not overridable.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  request per requester; bit i = requester i.
REQ-006 data_in  input  4*W  requester i word at data_in[i*W +: W].
REQ-007 grant  output  4  one-hot owner of the serial line; all-zero when idle.
REQ-008 gnt_id  output  2  binary index of current/last owner.
REQ-009 out  output  1  serial data bit, LSB first.
REQ-010 valid  output  1  out carries a payload bit this cycle.
REQ-011 done  output  1  one-cycle pulse: current owner's word fully sent.
REQ-012 empty  output  1  high when idle (no transfer in progress).

Function
REQ-013 FSM SHALL have states IDLE, SHIFT, DONE; every output SHALL be registered.
REQ-014 IDLE: req==0 -> stay; empty=1, valid=0, grant=0.
REQ-015 IDLE with req!=0 at edge e0 -> winner selected, shreg<=winner word, grant/gnt_id<=winner, cnt<=0, empty<=0, state<=SHIFT.
REQ-016 Arbitration SHALL be round-robin: search starts at ptr and wraps 3->0; first set req bit wins.
REQ-017 ptr SHALL be reset to 0 and updated to (winner+1) mod 4 at the DONE edge.
REQ-018 SHIFT, edges e1..eW: out<=shreg[0], shreg<=shreg>>1, valid<=1, cnt<=cnt+1.
REQ-019 At edge eW (cnt==W-1 before increment), state<=DONE.
REQ-020 DONE edge e(W+1): valid<=0, out<=0, done<=1, grant<=0, ptr updated, empty<=1, state<=IDLE.
REQ-021 done SHALL be high exactly one cycle per word; gnt_id SHALL hold its value through the done cycle.
REQ-022 Latency: first bit valid one cycle after grant rises; W consecutive valid cycles with no gaps; each word occupies W+2 cycles.
REQ-023 New request SHALL be sampled no earlier than the edge after done; back-to-back words leave exactly one idle cycle between done and the next grant.
REQ-024 req and data_in SHALL be sampled only at e0; later changes, including req dropping, SHALL NOT affect the word in flight.
REQ-025 Owner continuing to hold req after done SHALL lose to any other requester under REQ-016.
REQ-026 cnt width SHALL be ceil(log2(W+1)) bits; no wrap during a word.
REQ-027 grant SHALL never have more than one bit set.

Reset
REQ-028 rst high SHALL immediately, without a clock, force state=IDLE, grant=0, gnt_id=0, out=0, valid=0, done=0, empty=1, ptr=0, cnt=0, shreg=0.
REQ-029 Reset mid-SHIFT SHALL abort the word; no done pulse for it; after release, arbitration restarts from requester 0.
REQ-030 First edge after rst falls SHALL be treated as a normal IDLE edge.

Verification
REQ-031 W=4, req=0001, data0=4'b1011 -> grant=0001 at e0; out 1,1,0,1 with valid on e1..e4; done=1 at e5; empty=1 at e5.
REQ-032 req=1111 held, distinct words -> grants in order 0,1,2,3,0; each word 6 cycles; exactly one idle cycle after each done.
REQ-033 ptr=2 (after serving 1), req=0011 -> requester 0 wins (wrap), then requester 1.
REQ-034 data_in and req changed to 0 on e2 of a word -> remaining bits unchanged from latched word; done still pulses at e5.
REQ-035 rst asserted between edges during e2 of a word -> valid, grant, done drop to 0 and empty rises to 1 asynchronously; with req=1000 after release, requester 3 is granted, with ptr=0.
REQ-036 Every cycle: grant one-hot or zero, valid implies !empty, done never in two consecutive cycles.
